// File: rtl/tiletest_hb_pkg.sv
// Shared encodings for the heartbeat receive monitor: mode values reported to software.
package tiletest_hb_pkg;

  localparam int unsigned MODE_W = 3;

  typedef enum logic [MODE_W-1:0] {
    HB_IDLE     = 3'd0,
    HB_PWM      = 3'd1,
    HB_BLINK    = 3'd2,
    HB_STUCK_LO = 3'd3,
    HB_STUCK_HI = 3'd4
  } hb_mode_e;

endpackage

// File: rtl/tiletest_sync2.sv
// Two-flop synchronizer for a single asynchronous level, async active-low reset to 0.
module tiletest_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/tiletest_heartbeat_monitor.sv
// Classifies a returned heartbeat line as PWM throb, blink or stuck, and measures
// PWM duty per window plus the length of each completed high run.
module tiletest_heartbeat_monitor
  import tiletest_hb_pkg::*;
#(
  parameter int unsigned PWM_BITS   = 8,
  parameter int unsigned SLOT_LOG2  = 19,
  parameter int unsigned STUCK_LOG2 = 24
) (
  input  logic                  sys_clk,
  input  logic                  rst_n,
  input  logic                  hb_in,
  output logic [MODE_W-1:0]     mode,
  output logic [PWM_BITS-1:0]   duty,
  output logic                  duty_valid,
  output logic [STUCK_LOG2-1:0] high_len,
  output logic                  len_valid
);

  localparam int unsigned CntW = PWM_BITS + 1;
  localparam int unsigned RunW = STUCK_LOG2 + 1;

  localparam logic [PWM_BITS-1:0]   DutyMax  = {PWM_BITS{1'b1}};
  localparam logic [STUCK_LOG2-1:0] LenMax   = {STUCK_LOG2{1'b1}};
  localparam logic [RunW-1:0]       RunMax   = {1'b1, {STUCK_LOG2{1'b0}}};
  localparam logic [RunW-1:0]       ShortLim = RunW'(1) << (SLOT_LOG2 - 1);

  logic hb_s;
  logic hb_d_q;
  logic rise_q, fall_q;
  logic edge_seen;
  logic stuck;

  logic [PWM_BITS-1:0]   win_q, win_d;
  logic [CntW-1:0]       hi_cnt_q, hi_cnt_d;
  logic [CntW-1:0]       hi_sum;
  logic [PWM_BITS-1:0]   duty_q, duty_d;
  logic                  duty_valid_q, duty_valid_d;
  logic [RunW-1:0]       run_q, run_d;
  logic [STUCK_LOG2-1:0] high_len_q, high_len_d;
  logic                  len_valid_q, len_valid_d;
  hb_mode_e              mode_q, mode_d;

  tiletest_sync2 u_sync (
    .clk   (sys_clk),
    .rst_n (rst_n),
    .d     (hb_in),
    .q     (hb_s)
  );

  // Edge pulses are registered, so hb_d_q is the level aligned with them.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      hb_d_q <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      hb_d_q <= hb_s;
      rise_q <= hb_s & ~hb_d_q;
      fall_q <= ~hb_s & hb_d_q;
    end
  end

  assign edge_seen = rise_q | fall_q;

  always_comb begin
    win_d        = win_q + 1'b1;
    hi_cnt_d     = hi_cnt_q + CntW'(hb_s);
    hi_sum       = hi_cnt_q + CntW'(hb_s);
    duty_d       = duty_q;
    duty_valid_d = 1'b0;
    if (&win_q) begin
      duty_d       = hi_sum[PWM_BITS] ? DutyMax : hi_sum[PWM_BITS-1:0];
      duty_valid_d = 1'b1;
      hi_cnt_d     = '0;
    end
  end

  always_comb begin
    run_d       = run_q;
    high_len_d  = high_len_q;
    len_valid_d = 1'b0;
    if (edge_seen) begin
      run_d = RunW'(1);
    end else if (run_q != RunMax) begin
      run_d = run_q + 1'b1;
    end
    if (fall_q) begin
      high_len_d  = run_q[STUCK_LOG2] ? LenMax : run_q[STUCK_LOG2-1:0];
      len_valid_d = 1'b1;
    end
  end

  // An edge in the same cycle as the timeout wins: it is about to clear the run counter.
  assign stuck = (run_q == RunMax) && !edge_seen;

  always_comb begin
    mode_d = mode_q;
    if (stuck) begin
      mode_d = hb_d_q ? HB_STUCK_HI : HB_STUCK_LO;
    end else if (fall_q) begin
      mode_d = (run_q < ShortLim) ? HB_PWM : HB_BLINK;
    end else if (rise_q && (mode_q == HB_STUCK_LO || mode_q == HB_STUCK_HI)) begin
      mode_d = HB_IDLE;
    end
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      win_q        <= '0;
      hi_cnt_q     <= '0;
      duty_q       <= '0;
      duty_valid_q <= 1'b0;
      run_q        <= '0;
      high_len_q   <= '0;
      len_valid_q  <= 1'b0;
      mode_q       <= HB_IDLE;
    end else begin
      win_q        <= win_d;
      hi_cnt_q     <= hi_cnt_d;
      duty_q       <= duty_d;
      duty_valid_q <= duty_valid_d;
      run_q        <= run_d;
      high_len_q   <= high_len_d;
      len_valid_q  <= len_valid_d;
      mode_q       <= mode_d;
    end
  end

  assign mode       = mode_q;
  assign duty       = duty_q;
  assign duty_valid = duty_valid_q;
  assign high_len   = high_len_q;
  assign len_valid  = len_valid_q;

endmodule

// File: tb/tb_tiletest_heartbeat_monitor.sv
// Scoreboard bench: window-aligned heartbeat stimulus pushes expected duty / run results,
// a negedge monitor pops and compares on duty_valid and len_valid.
module tb_tiletest_heartbeat_monitor;
  import tiletest_hb_pkg::*;

  logic       sys_clk = 1'b0;
  logic       rst_n;
  logic       hb_in;
  logic [2:0] mode;
  logic [7:0] duty;
  logic       duty_valid;
  logic [9:0] high_len;
  logic       len_valid;

  int n_cmp = 0;
  int n_bad = 0;

  int exp_duty_q[$];
  int exp_len_q[$];
  int exp_mode_q[$];

  tiletest_heartbeat_monitor #(
    .PWM_BITS   (8),
    .SLOT_LOG2  (6),
    .STUCK_LOG2 (10)
  ) dut (
    .sys_clk    (sys_clk),
    .rst_n      (rst_n),
    .hb_in      (hb_in),
    .mode       (mode),
    .duty       (duty),
    .duty_valid (duty_valid),
    .high_len   (high_len),
    .len_valid  (len_valid)
  );

  always #5 sys_clk = ~sys_clk;

  // Monitor: consumes one expectation per output pulse.
  always @(negedge sys_clk) begin
    int e, em;
    if (rst_n === 1'b1) begin
      if (duty_valid === 1'b1) begin
        n_cmp++;
        if (exp_duty_q.size() == 0) begin
          n_bad++;
          $display("FAIL duty_unexpected: got duty %0d with no expectation queued", duty);
        end else begin
          e = exp_duty_q.pop_front();
          if (duty !== 8'(e)) begin
            n_bad++;
            $display("FAIL duty: got %0d, expected %0d", duty, e);
          end
        end
      end
      if (len_valid === 1'b1) begin
        n_cmp++;
        if (exp_len_q.size() == 0) begin
          n_bad++;
          $display("FAIL len_unexpected: got high_len %0d with no expectation queued",
                   high_len);
        end else begin
          e  = exp_len_q.pop_front();
          em = exp_mode_q.pop_front();
          if (high_len !== 10'(e) || mode !== 3'(em)) begin
            n_bad++;
            $display("FAIL high_len/mode: got len %0d mode %0d, expected len %0d mode %0d",
                     high_len, mode, e, em);
          end
        end
      end
    end
  end

  // One DUT window of stimulus; hb_in leads the synchronized level by two cycles, so
  // index i here lands in window slot i. elen < 0 means no falling edge in this window.
  task automatic drive_win(input int first_i, input int lo, input int hi, input int edu,
                           input int elen, input hb_mode_e emode);
    exp_duty_q.push_back(edu);
    if (elen >= 0) begin
      exp_len_q.push_back(elen);
      exp_mode_q.push_back(int'(emode));
    end
    for (int i = first_i; i < 256; i++) begin
      hb_in = (i >= lo && i < hi);
      @(negedge sys_clk);
    end
  endtask

  task automatic check_mode(input string name, input hb_mode_e exp);
    n_cmp++;
    if (mode !== exp) begin
      n_bad++;
      $display("FAIL mode_%s: got %0d, expected %0d", name, mode, exp);
    end
  endtask

  task automatic check_zero(input string name, input int got);
    n_cmp++;
    if (got != 0) begin
      n_bad++;
      $display("FAIL reset_%s: got %0d, expected 0", name, got);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    hb_in = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge sys_clk);
    #1;
    check_zero("mode_init", int'(mode));
    check_zero("duty_init", int'(duty));
    check_zero("len_init", int'(high_len));
    @(negedge sys_clk);
    rst_n = 1'b1;

    // Line held low: idle, then stuck low once the run counter saturates.
    drive_win(2, 0, 0, 0, -1, HB_IDLE);
    repeat (3) drive_win(0, 0, 0, 0, -1, HB_IDLE);
    check_mode("idle_before_timeout", HB_IDLE);
    drive_win(0, 0, 0, 0, -1, HB_IDLE);
    check_mode("stuck_lo", HB_STUCK_LO);

    // Short PWM high time (20 of 256) classifies as throb.
    repeat (4) drive_win(0, 0, 20, 20, 20, HB_PWM);
    check_mode("pwm", HB_PWM);

    // Near-full duty, then held high: duty saturates at 255, then stuck high.
    repeat (2) drive_win(0, 0, 255, 255, 255, HB_BLINK);
    repeat (4) drive_win(0, 0, 256, 255, -1, HB_IDLE);
    check_mode("before_stuck_hi", HB_BLINK);
    drive_win(0, 0, 256, 255, -1, HB_IDLE);
    check_mode("stuck_hi", HB_STUCK_HI);

    // Release from stuck high: saturated run length, long run.
    drive_win(0, 0, 10, 10, 1023, HB_BLINK);
    check_mode("after_stuck_hi", HB_BLINK);
    drive_win(0, 100, 110, 10, 10, HB_PWM);
    check_mode("short_pulse", HB_PWM);

    // Blink: 64 high of every 1024, then a 10-cycle pulse back to PWM.
    drive_win(0, 0, 64, 64, 64, HB_BLINK);
    repeat (3) drive_win(0, 0, 0, 0, -1, HB_IDLE);
    check_mode("blink_gap", HB_BLINK);
    drive_win(0, 0, 64, 64, 64, HB_BLINK);
    check_mode("blink", HB_BLINK);
    drive_win(0, 50, 60, 10, 10, HB_PWM);
    check_mode("blink_to_pwm", HB_PWM);

    // Stuck low, single rising edge -> idle, completing short pulse -> PWM.
    repeat (4) drive_win(0, 0, 0, 0, -1, HB_IDLE);
    check_mode("stuck_lo_again", HB_STUCK_LO);
    drive_win(0, 250, 256, 6, -1, HB_IDLE);
    check_mode("rise_from_stuck", HB_IDLE);
    drive_win(0, 0, 10, 10, 16, HB_PWM);
    check_mode("pwm_after_idle", HB_PWM);

    // Reset mid-window while in blink.
    drive_win(0, 0, 64, 64, 64, HB_BLINK);
    check_mode("blink_before_reset", HB_BLINK);
    hb_in = 1'b0;
    repeat (100) @(negedge sys_clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_zero("mode", int'(mode));
    check_zero("duty", int'(duty));
    check_zero("duty_valid", int'(duty_valid));
    check_zero("high_len", int'(high_len));
    check_zero("len_valid", int'(len_valid));
    repeat (3) @(negedge sys_clk);
    exp_duty_q.push_back(0);
    rst_n = 1'b1;
    n = 0;
    while (n < 400) begin
      @(negedge sys_clk);
      n++;
      if (duty_valid === 1'b1) break;
    end
    n_cmp++;
    if (n != 256) begin
      n_bad++;
      $display("FAIL duty_valid_after_reset: got cycle %0d, expected 256", n);
    end

    repeat (4) @(negedge sys_clk);
    n_cmp++;
    if (exp_duty_q.size() != 0) begin
      n_bad++;
      $display("FAIL duty_pending: got %0d unconsumed, expected 0", exp_duty_q.size());
    end
    n_cmp++;
    if (exp_len_q.size() != 0) begin
      n_bad++;
      $display("FAIL len_pending: got %0d unconsumed, expected 0", exp_len_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
